// File: rtl/handshaking_master.sv
// -----------------------------------------------------------------------------
// handshaking_master
//
// Transmit end of a valid/ready byte link. A local producer pushes bytes into
// a small FIFO. A two-state FSM (IDLE/SEND) moves FIFO entries one at a time
// into a registered output stage. Each beat is held there until the receiver
// accepts it. data_valid and data_out come straight from flops, so there is no
// combinational path from data_ready to data_valid.
//
// Optional build macro:
//   HANDSHAKE_TIMEOUT_EN - adds a 16-bit stall counter and a sticky timeout
//                          flag. When the macro is undefined, timeout is
//                          tied to 0.
//
// Parameters:
//   DATA_WIDTH     - width of wr_data / data_out and of the FIFO entries
//   DEPTH          - number of FIFO entries (power of 2, minimum 2)
//   TIMEOUT_CYCLES - stall limit, 1..65535 (timeout build only)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   wr_en      in   local push request
//   wr_data    in   local push data
//   full       out  FIFO full; pushes are ignored
//   empty      out  FIFO empty
//   level      out  FIFO occupancy, 0..DEPTH
//   overflow   out  one-cycle pulse after a push was attempted while full
//   data_out   out  handshake data to the receiver
//   data_valid out  data_out holds a valid beat
//   data_ready in   receiver ready (registered on the receiver side)
//   timeout    out  sticky stall flag
// -----------------------------------------------------------------------------
module handshaking_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;

    // Output stage and FSM
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // full is judged on the pre-edge level. A push into a full FIFO is
    // dropped even if a pop frees a slot on the same edge.
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = wr_en && !w_full;

    // The FSM is the only consumer of the FIFO. In IDLE it fetches the head
    // as soon as the FIFO has data. In SEND it fetches the next entry only
    // on the edge where the current beat is accepted.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            case (r_state)
                ST_IDLE: w_pop = 1'b1;
                ST_SEND: w_pop = data_ready;
                default: w_pop = 1'b0;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Storage has no reset. On reset its contents are discarded simply by
    // clearing the pointers and the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH through natural overflow, because DEPTH is
    // a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            r_overflow <= wr_en && w_full;
        end
    end

    // Transmit FSM with registered outputs. A beat in SEND never changes or
    // drops until data_ready is seen on an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_data_out   <= w_head;
                        r_data_valid <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (data_ready) begin
                        if (!w_empty) begin
                            // The beat is accepted and the next one is
                            // loaded on the same edge, giving one beat per
                            // cycle.
                            r_data_out <= w_head;
                        end else begin
                            r_data_valid <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_TIMEOUT_EN
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_stall_cnt;
    logic        r_timeout;

    // The flag is raised on the edge where the counter reaches STALL_LIMIT,
    // so timeout reads 1 right after the STALL_LIMIT-th stalled cycle. The
    // counter saturates, so a very long stall cannot wrap it back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == ST_SEND && !data_ready) begin
                if (r_stall_cnt != 16'hFFFF) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
                if (r_stall_cnt == STALL_LIMIT - 16'd1) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign full       = w_full;
    assign empty      = w_empty;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_handshaking_master.sv
// -----------------------------------------------------------------------------
// tb_handshaking_master
//
// Directed bench for handshaking_master in its default build (DEPTH=4,
// DATA_WIDTH=8, timeout disabled). Inputs are driven 1 ns after each rising
// edge, and outputs are sampled at that same point. Every expected value is
// a hand-computed constant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_handshaking_master;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       timeout;

    int n_tests;
    int n_fail;

    handshaking_master #(
        .DATA_WIDTH     (8),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks data_valid, data_out and level together after an edge.
    task automatic check_beat(input string tag, input logic v, input logic [7:0] d, input logic [2:0] l);
        check({tag, ".valid"}, {31'd0, data_valid}, {31'd0, v});
        if (v) check({tag, ".data"}, {24'd0, data_out}, {24'd0, d});
        check({tag, ".level"}, {29'd0, level}, {29'd0, l});
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        wr_en      = 1'b1;
        wr_data    = 8'hFF;
        data_ready = 1'b0;

        // Reset is held while pushes are requested.
        tick(); tick(); tick();
        check("rst.valid",    {31'd0, data_valid}, 32'd0);
        check("rst.data",     {24'd0, data_out},   32'd0);
        check("rst.level",    {29'd0, level},      32'd0);
        check("rst.empty",    {31'd0, empty},      32'd1);
        check("rst.full",     {31'd0, full},       32'd0);
        check("rst.overflow", {31'd0, overflow},   32'd0);
        check("rst.timeout",  {31'd0, timeout},    32'd0);

        // Release reset, then push 0xA5. valid appears one edge after the
        // push edge.
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check_beat("lat.push", 1'b0, 8'h00, 3'd1);
        tick();
        check_beat("lat.out", 1'b1, 8'hA5, 3'd0);
        data_ready = 1'b1;
        tick();
        check_beat("lat.done", 1'b0, 8'h00, 3'd0);

        // Back-to-back transfer with ready held high.
        wr_en = 1'b1; wr_data = 8'h01; tick();
        check_beat("b2b.e1", 1'b0, 8'h00, 3'd1);
        wr_data = 8'h02; tick();
        check_beat("b2b.e2", 1'b1, 8'h01, 3'd1);
        wr_data = 8'h03; tick();
        check_beat("b2b.e3", 1'b1, 8'h02, 3'd1);
        wr_data = 8'h04; tick();
        check_beat("b2b.e4", 1'b1, 8'h03, 3'd1);
        wr_en = 1'b0; tick();
        check_beat("b2b.e5", 1'b1, 8'h04, 3'd0);
        tick();
        check_beat("b2b.idle", 1'b0, 8'h00, 3'd0);
        check("b2b.empty", {31'd0, empty}, 32'd1);

        // Backpressure: five pushes fill the output stage plus the FIFO,
        // and a sixth push is dropped.
        data_ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h10; tick();
        wr_data = 8'h11; tick();
        check_beat("bp.first", 1'b1, 8'h10, 3'd1);
        wr_data = 8'h12; tick();
        wr_data = 8'h13; tick();
        wr_data = 8'h14; tick();
        check_beat("bp.fill", 1'b1, 8'h10, 3'd4);
        check("bp.full", {31'd0, full}, 32'd1);
        check("bp.ovf0", {31'd0, overflow}, 32'd0);
        wr_data = 8'h15; tick();
        check("bp.ovf1", {31'd0, overflow}, 32'd1);
        check_beat("bp.drop", 1'b1, 8'h10, 3'd4);
        wr_en = 1'b0; tick();
        check("bp.ovf_pulse", {31'd0, overflow}, 32'd0);
        check_beat("bp.hold", 1'b1, 8'h10, 3'd4);
        data_ready = 1'b1; tick();
        check_beat("bp.d11", 1'b1, 8'h11, 3'd3);
        tick();
        check_beat("bp.d12", 1'b1, 8'h12, 3'd2);
        // Push and pop on the same edge at level 2.
        wr_en = 1'b1; wr_data = 8'h20; tick();
        check_beat("pp.d13", 1'b1, 8'h13, 3'd2);
        check("pp.ovf", {31'd0, overflow}, 32'd0);
        wr_en = 1'b0; tick();
        check_beat("pp.d14", 1'b1, 8'h14, 3'd1);
        tick();
        check_beat("pp.d20", 1'b1, 8'h20, 3'd0);
        tick();
        check_beat("pp.idle", 1'b0, 8'h00, 3'd0);

        // Push while full on the same edge as a pop: the push is dropped.
        data_ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h30; tick();
        wr_data = 8'h31; tick();
        wr_data = 8'h32; tick();
        wr_data = 8'h33; tick();
        wr_data = 8'h34; tick();
        check_beat("fp.fill", 1'b1, 8'h30, 3'd4);
        wr_data = 8'h35; data_ready = 1'b1; tick();
        check("fp.ovf", {31'd0, overflow}, 32'd1);
        check_beat("fp.d31", 1'b1, 8'h31, 3'd3);
        wr_en = 1'b0; tick();
        check("fp.ovf_clr", {31'd0, overflow}, 32'd0);
        check_beat("fp.d32", 1'b1, 8'h32, 3'd2);
        tick();
        check_beat("fp.d33", 1'b1, 8'h33, 3'd1);
        tick();
        check_beat("fp.d34", 1'b1, 8'h34, 3'd0);
        tick();
        check_beat("fp.no35", 1'b0, 8'h00, 3'd0);

        // Asynchronous reset between edges while a beat is in flight.
        data_ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h77; tick();
        wr_data = 8'h78; tick();
        wr_en = 1'b0;
        check_beat("ar.pre", 1'b1, 8'h77, 3'd1);
        #2 rst = 1'b0;
        #1;
        check("ar.valid", {31'd0, data_valid}, 32'd0);
        check("ar.data",  {24'd0, data_out},   32'd0);
        check("ar.level", {29'd0, level},      32'd0);
        check("ar.empty", {31'd0, empty},      32'd1);
        tick();
        #2 rst = 1'b1;
        data_ready = 1'b1;
        tick();
        check_beat("ar.post1", 1'b0, 8'h00, 3'd0);
        tick();
        check_beat("ar.post2", 1'b0, 8'h00, 3'd0);
        check("ar.data_clear", {24'd0, data_out}, 32'd0);
        check("ar.timeout", {31'd0, timeout}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
